// File: rtl/aximm_to_axis_burst_if.sv
// AXI4 write slave, tied-off read side and AXI-Stream master bundle for aximm_to_axis_burst.
// AXIS_OUT_TUSER is present only when AXIS_TUSER_ADDR_EN is defined.
interface aximm_to_axis_burst_if #(
    parameter int DW  = 512,
    parameter int AW  = 64,
    parameter int IDW = 4
);
    logic [AW-1:0]   S_AXI_AWADDR;
    logic [IDW-1:0]  S_AXI_AWID;
    logic [7:0]      S_AXI_AWLEN;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WLAST;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [IDW-1:0]  S_AXI_BID;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RLAST;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;
    logic [DW-1:0]   AXIS_OUT_TDATA;
    logic [DW/8-1:0] AXIS_OUT_TKEEP;
    logic            AXIS_OUT_TLAST;
    logic            AXIS_OUT_TVALID;
    logic            AXIS_OUT_TREADY;
`ifdef AXIS_TUSER_ADDR_EN
    logic [AW-1:0]   AXIS_OUT_TUSER;
`endif

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY,
        output AXIS_OUT_TDATA, AXIS_OUT_TKEEP, AXIS_OUT_TLAST, AXIS_OUT_TVALID,
        input  AXIS_OUT_TREADY
`ifdef AXIS_TUSER_ADDR_EN
        , output AXIS_OUT_TUSER
`endif
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY,
        input  AXIS_OUT_TDATA, AXIS_OUT_TKEEP, AXIS_OUT_TLAST, AXIS_OUT_TVALID,
        output AXIS_OUT_TREADY
`ifdef AXIS_TUSER_ADDR_EN
        , input AXIS_OUT_TUSER
`endif
    );
endinterface

// File: rtl/aximm_to_axis_burst.sv
// AXI4-MM write slave to AXI-Stream bridge: AW queue, AWLEN-driven TLAST, in-order B responses.
// Define AXIS_TUSER_ADDR_EN to store AWADDR and emit per-beat byte addresses on AXIS_OUT_TUSER.
module aximm_to_axis_burst #(
    parameter int DW     = 512,
    parameter int AW     = 64,
    parameter int IDW    = 4,
    parameter int QDEPTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    aximm_to_axis_burst_if.slave axi,
    output logic [15:0]          ERR_COUNT
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] QFULL       = CW'(QDEPTH);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    logic [IDW-1:0] r_aw_id  [QDEPTH];
    logic [7:0]     r_aw_len [QDEPTH];
`ifdef AXIS_TUSER_ADDR_EN
    logic [AW-1:0]  r_aw_addr [QDEPTH];
`endif
    logic [PW-1:0]  r_aw_wp;
    logic [PW-1:0]  r_aw_rp;
    logic [CW-1:0]  r_aw_cnt;

    logic [IDW-1:0] r_b_id   [QDEPTH];
    logic [1:0]     r_b_resp [QDEPTH];
    logic [PW-1:0]  r_b_wp;
    logic [PW-1:0]  r_b_rp;
    logic [CW-1:0]  r_b_cnt;

    logic [7:0]     r_beat_cnt;
    logic           r_mismatch;
    logic [15:0]    r_err_count;

    logic w_aw_full, w_aw_empty, w_b_full, w_b_empty;
    logic w_go, w_tlast, w_aw_push, w_w_hs, w_aw_pop, w_b_pop, w_burst_err;

    assign w_aw_full  = (r_aw_cnt == QFULL);
    assign w_aw_empty = (r_aw_cnt == '0);
    assign w_b_full   = (r_b_cnt == QFULL);
    assign w_b_empty  = (r_b_cnt == '0);

    // B-full blocks W even when a B pop is happening this cycle.
    assign w_go    = resetn & ~w_aw_empty & ~w_b_full;
    assign w_tlast = (r_beat_cnt == r_aw_len[r_aw_rp]);

    assign axi.S_AXI_AWREADY   = resetn & ~w_aw_full;
    assign axi.S_AXI_WREADY    = axi.AXIS_OUT_TREADY & w_go;
    assign axi.AXIS_OUT_TVALID = axi.S_AXI_WVALID & w_go;
    assign axi.AXIS_OUT_TDATA  = axi.S_AXI_WDATA;
    assign axi.AXIS_OUT_TKEEP  = axi.S_AXI_WSTRB;
    assign axi.AXIS_OUT_TLAST  = w_tlast;

    assign w_aw_push   = axi.S_AXI_AWVALID & axi.S_AXI_AWREADY;
    assign w_w_hs      = axi.S_AXI_WVALID & axi.S_AXI_WREADY;
    assign w_aw_pop    = w_w_hs & w_tlast;
    assign w_burst_err = r_mismatch | (axi.S_AXI_WLAST != w_tlast);

    assign axi.S_AXI_BVALID = resetn & ~w_b_empty;
    assign axi.S_AXI_BID    = r_b_id[r_b_rp];
    assign axi.S_AXI_BRESP  = r_b_resp[r_b_rp];
    assign w_b_pop          = axi.S_AXI_BVALID & axi.S_AXI_BREADY;

    assign axi.S_AXI_ARREADY = 1'b0;
    assign axi.S_AXI_RDATA   = '0;
    assign axi.S_AXI_RRESP   = 2'b00;
    assign axi.S_AXI_RLAST   = 1'b0;
    assign axi.S_AXI_RVALID  = 1'b0;

    assign ERR_COUNT = r_err_count;

`ifdef AXIS_TUSER_ADDR_EN
    localparam logic [AW-1:0] BEAT_BYTES = AW'(DW / 8);
    logic [AW-1:0] w_beat_ext;
    assign w_beat_ext          = {{(AW-8){1'b0}}, r_beat_cnt};
    assign axi.AXIS_OUT_TUSER  = r_aw_addr[r_aw_rp] + w_beat_ext * BEAT_BYTES;
    logic w_unused;
    assign w_unused = axi.S_AXI_ARVALID ^ axi.S_AXI_RREADY;
`else
    logic w_unused;
    assign w_unused = axi.S_AXI_ARVALID ^ axi.S_AXI_RREADY ^ (^axi.S_AXI_AWADDR);
`endif

    // Queue storage carries no reset; validity is tracked by the count registers.
    always_ff @(posedge clk) begin
        if (w_aw_push) begin
            r_aw_id[r_aw_wp]   <= axi.S_AXI_AWID;
            r_aw_len[r_aw_wp]  <= axi.S_AXI_AWLEN;
`ifdef AXIS_TUSER_ADDR_EN
            r_aw_addr[r_aw_wp] <= axi.S_AXI_AWADDR;
`endif
        end
        if (w_aw_pop) begin
            r_b_id[r_b_wp]   <= r_aw_id[r_aw_rp];
            r_b_resp[r_b_wp] <= w_burst_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_aw_wp     <= '0;
            r_aw_rp     <= '0;
            r_aw_cnt    <= '0;
            r_b_wp      <= '0;
            r_b_rp      <= '0;
            r_b_cnt     <= '0;
            r_beat_cnt  <= '0;
            r_mismatch  <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_aw_push) r_aw_wp <= r_aw_wp + PW'(1);
            if (w_aw_pop)  r_aw_rp <= r_aw_rp + PW'(1);
            case ({w_aw_push, w_aw_pop})
                2'b10:   r_aw_cnt <= r_aw_cnt + CW'(1);
                2'b01:   r_aw_cnt <= r_aw_cnt - CW'(1);
                default: r_aw_cnt <= r_aw_cnt;
            endcase

            if (w_aw_pop) r_b_wp <= r_b_wp + PW'(1);
            if (w_b_pop)  r_b_rp <= r_b_rp + PW'(1);
            case ({w_aw_pop, w_b_pop})
                2'b10:   r_b_cnt <= r_b_cnt + CW'(1);
                2'b01:   r_b_cnt <= r_b_cnt - CW'(1);
                default: r_b_cnt <= r_b_cnt;
            endcase

            if (w_w_hs) begin
                if (w_tlast) begin
                    r_beat_cnt <= '0;
                    r_mismatch <= 1'b0;
                    if (w_burst_err && (r_err_count != 16'hFFFF))
                        r_err_count <= r_err_count + 16'd1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 8'd1;
                    r_mismatch <= w_burst_err;
                end
            end
        end
    end
endmodule

// File: tb/tb_aximm_to_axis_burst.sv
// Scoreboard bench for aximm_to_axis_burst: directed bursts, expected stream beats and B responses queued.
module tb_aximm_to_axis_burst;
    localparam int DW     = 512;
    localparam int AW     = 64;
    localparam int IDW    = 4;
    localparam int QDEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] err_count;
    int          n_checks = 0;
    int          n_fail = 0;

    aximm_to_axis_burst_if #(.DW(DW), .AW(AW), .IDW(IDW)) bus ();

    aximm_to_axis_burst #(.DW(DW), .AW(AW), .IDW(IDW), .QDEPTH(QDEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .axi       (bus.slave),
        .ERR_COUNT (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] keep;
        logic            last;
        logic            chk_user;
        logic [AW-1:0]   user;
    } s_beat_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [1:0]     resp;
    } b_t;

    s_beat_t exp_s[$];
    b_t      exp_b[$];

    function automatic logic [DW-1:0] mkdata(input logic [31:0] s);
        return {(DW/32){s}};
    endfunction

    function automatic logic [DW/8-1:0] mkkeep(input logic [3:0] k);
        return {(DW/32){k}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [IDW-1:0] id, input logic [7:0] len, input logic [AW-1:0] addr);
        logic ok;
        ok = 1'b0;
        bus.S_AXI_AWID    = id;
        bus.S_AXI_AWLEN   = len;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWVALID = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = bus.S_AXI_AWREADY;
            tick();
        end
        bus.S_AXI_AWVALID = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL aw_timeout: id=%0d not accepted within bound", id);
        end
    endtask

    task automatic drive_w(input logic [31:0] seed, input logic [3:0] k, input logic wlast,
                           input logic tlast, input logic chk_user, input logic [AW-1:0] user);
        s_beat_t e;
        e.data = mkdata(seed);
        e.keep = mkkeep(k);
        e.last = tlast;
        e.chk_user = chk_user;
        e.user = user;
        exp_s.push_back(e);
        bus.S_AXI_WDATA  = e.data;
        bus.S_AXI_WSTRB  = e.keep;
        bus.S_AXI_WLAST  = wlast;
        bus.S_AXI_WVALID = 1'b1;
    endtask

    task automatic wait_w();
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = bus.S_AXI_WREADY;
            tick();
        end
        bus.S_AXI_WVALID = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL w_timeout: beat not accepted within bound");
        end
    endtask

    task automatic send_w(input logic [31:0] seed, input logic [3:0] k, input logic wlast, input logic tlast);
        drive_w(seed, k, wlast, tlast, 1'b0, '0);
        wait_w();
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 200; t++) begin
            if (exp_s.size() == 0 && exp_b.size() == 0) break;
            tick();
        end
        check({name, "_drain_s"}, 64'(exp_s.size()), 64'd0);
        check({name, "_drain_b"}, 64'(exp_b.size()), 64'd0);
    endtask

    // Monitor: compare every stream and B handshake against the queued expectations.
    always @(negedge clk) begin
        s_beat_t e;
        b_t      eb;
        if (resetn) begin
            if (bus.AXIS_OUT_TVALID && bus.AXIS_OUT_TREADY) begin
                if (exp_s.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_unexpected: beat data=0x%0h with no expectation", bus.AXIS_OUT_TDATA[31:0]);
                end else begin
                    e = exp_s.pop_front();
                    check("stream_data", 64'(bus.AXIS_OUT_TDATA[63:0]), 64'(e.data[63:0]));
                    n_checks++;
                    if (bus.AXIS_OUT_TDATA !== e.data) begin
                        n_fail++;
                        $display("FAIL stream_data_full: got 0x%0h expected 0x%0h", bus.AXIS_OUT_TDATA, e.data);
                    end
                    check("stream_keep", 64'(bus.AXIS_OUT_TKEEP), 64'(e.keep));
                    check("stream_tlast", 64'(bus.AXIS_OUT_TLAST), 64'(e.last));
`ifdef AXIS_TUSER_ADDR_EN
                    if (e.chk_user) check("stream_tuser", 64'(bus.AXIS_OUT_TUSER), 64'(e.user));
`endif
                end
            end
            if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
                if (exp_b.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_unexpected: bid=%0d bresp=%0d with no expectation", bus.S_AXI_BID, bus.S_AXI_BRESP);
                end else begin
                    eb = exp_b.pop_front();
                    check("b_id", 64'(bus.S_AXI_BID), 64'(eb.id));
                    check("b_resp", 64'(bus.S_AXI_BRESP), 64'(eb.resp));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWID = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        bus.AXIS_OUT_TREADY = 1'b1;

        // Reset with valids asserted: nothing may be accepted.
        repeat (3) tick();
        @(negedge clk);
        check("rst_awready", 64'(bus.S_AXI_AWREADY), 64'd0);
        check("rst_wready", 64'(bus.S_AXI_WREADY), 64'd0);
        check("rst_tvalid", 64'(bus.AXIS_OUT_TVALID), 64'd0);
        check("rst_bvalid", 64'(bus.S_AXI_BVALID), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_awready", 64'(bus.S_AXI_AWREADY), 64'd1);
        check("post_rst_wready", 64'(bus.S_AXI_WREADY), 64'd0);
        tick();

        // Single burst, 4 beats, matching WLAST.
        exp_b.push_back('{id: 4'd3, resp: 2'd0});
        send_aw(4'd3, 8'd3, '0);
        @(negedge clk);
        check("aw_to_w_latency", 64'(bus.S_AXI_WREADY), 64'd1);
        tick();
        send_w(32'hA000_0000, 4'hF, 1'b0, 1'b0);
        send_w(32'hA000_0001, 4'h3, 1'b0, 1'b0);
        send_w(32'hA000_0002, 4'hC, 1'b0, 1'b0);
        send_w(32'hA000_0003, 4'h1, 1'b1, 1'b1);
        drain("single");
        check("single_err_count", 64'(err_count), 64'd0);

        // W presented before its AW must stall.
        exp_b.push_back('{id: 4'd5, resp: 2'd0});
        drive_w(32'hB000_0000, 4'hF, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("early_wready", 64'(bus.S_AXI_WREADY), 64'd0);
            check("early_tvalid", 64'(bus.AXIS_OUT_TVALID), 64'd0);
            tick();
        end
        bus.S_AXI_AWID = 4'd5; bus.S_AXI_AWLEN = 8'd1; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        check("early_aw_cycle_awready", 64'(bus.S_AXI_AWREADY), 64'd1);
        check("early_aw_cycle_wready", 64'(bus.S_AXI_WREADY), 64'd0);
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        wait_w();
        send_w(32'hB000_0001, 4'hF, 1'b1, 1'b1);
        drain("early");

        // WLAST on beat 1 of a 2-beat burst.
        exp_b.push_back('{id: 4'd6, resp: 2'd2});
        send_aw(4'd6, 8'd1, '0);
        send_w(32'hC000_0000, 4'hF, 1'b1, 1'b0);
        send_w(32'hC000_0001, 4'hF, 1'b0, 1'b1);
        drain("mismatch1");
        check("mismatch1_err_count", 64'(err_count), 64'd1);

        // WLAST never asserted in a 3-beat burst.
        exp_b.push_back('{id: 4'd9, resp: 2'd2});
        send_aw(4'd9, 8'd2, '0);
        send_w(32'hC100_0000, 4'hF, 1'b0, 1'b0);
        send_w(32'hC100_0001, 4'hF, 1'b0, 1'b0);
        send_w(32'hC100_0002, 4'hF, 1'b0, 1'b1);
        drain("mismatch2");
        check("mismatch2_err_count", 64'(err_count), 64'd2);

        // A clean burst right after must report OKAY.
        exp_b.push_back('{id: 4'd10, resp: 2'd0});
        send_aw(4'd10, 8'd0, '0);
        send_w(32'hC200_0000, 4'hF, 1'b1, 1'b1);
        drain("clean_after_err");
        check("clean_err_count", 64'(err_count), 64'd2);

        // Backpressure: BREADY low, fill AW queue, then B queue.
        bus.S_AXI_BREADY = 1'b0;
        for (int i = 0; i < 6; i++) exp_b.push_back('{id: IDW'(i), resp: 2'd0});
        for (int i = 0; i < 4; i++) send_aw(IDW'(i), 8'd0, '0);
        @(negedge clk);
        check("aw_full_awready", 64'(bus.S_AXI_AWREADY), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) send_w(32'hD000_0000 + 32'(i), 4'hF, 1'b1, 1'b1);
        send_aw(4'd4, 8'd0, '0);
        send_aw(4'd5, 8'd0, '0);
        drive_w(32'hD000_0004, 4'hF, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b_full_wready", 64'(bus.S_AXI_WREADY), 64'd0);
            check("b_full_tvalid", 64'(bus.AXIS_OUT_TVALID), 64'd0);
            tick();
        end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        check("b_pop_cycle_bvalid", 64'(bus.S_AXI_BVALID), 64'd1);
        check("b_pop_cycle_wready", 64'(bus.S_AXI_WREADY), 64'd0);
        tick();
        wait_w();
        send_w(32'hD000_0005, 4'hF, 1'b1, 1'b1);
        drain("backpressure");

        // Reset in the middle of an 8-beat burst.
        send_aw(4'd7, 8'd7, '0);
        send_w(32'hE000_0000, 4'hF, 1'b0, 1'b0);
        send_w(32'hE000_0001, 4'hF, 1'b0, 1'b0);
        send_w(32'hE000_0002, 4'hF, 1'b0, 1'b0);
        resetn = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("midrst_bvalid", 64'(bus.S_AXI_BVALID), 64'd0);
        check("midrst_err_count", 64'(err_count), 64'd0);
        tick();
        resetn = 1'b1;
        bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        check("midrst_after_wready", 64'(bus.S_AXI_WREADY), 64'd0);
        check("midrst_after_bvalid", 64'(bus.S_AXI_BVALID), 64'd0);
        tick();
        bus.S_AXI_WVALID = 1'b0;
        exp_b.push_back('{id: 4'd8, resp: 2'd0});
        send_aw(4'd8, 8'd0, '0);
        send_w(32'hE000_0008, 4'hF, 1'b1, 1'b1);
        drain("midrst");
        check("midrst_new_err_count", 64'(err_count), 64'd0);

`ifdef AXIS_TUSER_ADDR_EN
        // TUSER byte addresses, 64 bytes per 512-bit beat.
        exp_b.push_back('{id: 4'd1, resp: 2'd0});
        send_aw(4'd1, 8'd2, 64'h1000);
        drive_w(32'hF000_0000, 4'hF, 1'b0, 1'b0, 1'b1, 64'h1000); wait_w();
        drive_w(32'hF000_0001, 4'hF, 1'b0, 1'b0, 1'b1, 64'h1040); wait_w();
        drive_w(32'hF000_0002, 4'hF, 1'b1, 1'b1, 1'b1, 64'h1080); wait_w();
        drain("tuser");
`endif

        repeat (10) tick();
        check("final_exp_s_empty", 64'(exp_s.size()), 64'd0);
        check("final_exp_b_empty", 64'(exp_b.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aximm_to_axis_burst.md
Name: aximm_to_axis_burst

Overview:
- Converts the write side of an AXI4 memory-mapped slave into an AXI-Stream, with full burst tracking.
- Queues AW requests and counts W beats against AWLEN, so TLAST is generated internally rather than trusted from WLAST.
- Returns one B response per burst, carrying the correct BID; BRESP is SLVERR when WLAST disagrees with AWLEN.
- Sits between a DMA/PCIe AXI-MM master and stream consumers (packet FIFOs, data movers); the read side is tied off.

Parameters:
- DW, 512, data width in bits; multiple of 8.
- AW, 64, address width.
- IDW, 4, AXI ID width.
- QDEPTH, 4, depth of the AW queue and the B queue; power of two, at least 2.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- S_AXI_AWADDR  in  AW  burst start address
- S_AXI_AWID  in  IDW  burst ID
- S_AXI_AWLEN  in  8  beats minus 1
- S_AXI_AWVALID  in  1  AW valid
- S_AXI_AWREADY  out  1  AW ready
- S_AXI_WDATA  in  DW  write data
- S_AXI_WSTRB  in  DW/8  byte strobes
- S_AXI_WLAST  in  1  master's last-beat flag
- S_AXI_WVALID  in  1  W valid
- S_AXI_WREADY  out  1  W ready
- S_AXI_BID  out  IDW  response ID
- S_AXI_BRESP  out  2  OKAY (0) or SLVERR (2)
- S_AXI_BVALID  out  1  B valid
- S_AXI_BREADY  in  1  B ready
- S_AXI_ARVALID  in  1  ignored
- S_AXI_ARREADY  out  1  constant 0
- S_AXI_RDATA  out  DW  constant 0
- S_AXI_RRESP  out  2  constant 0
- S_AXI_RLAST  out  1  constant 0
- S_AXI_RVALID  out  1  constant 0
- S_AXI_RREADY  in  1  ignored
- AXIS_OUT_TDATA  out  DW  equals WDATA
- AXIS_OUT_TKEEP  out  DW/8  equals WSTRB
- AXIS_OUT_TLAST  out  1  generated last beat
- AXIS_OUT_TVALID  out  1  stream valid
- AXIS_OUT_TREADY  in  1  stream ready
- ERR_COUNT  out  16  saturating count of mismatched bursts

Behaviour:
- Reset (synchronous, active-low, clock clk):
  - Both queues empty; beat counter 0; ERR_COUNT 0; mismatch flag 0.
  - AWREADY is 0 while resetn is 0; WREADY, TVALID and BVALID are 0 during reset.
- AW queue:
  - AWREADY = ~aw_full.
  - On AWVALID & AWREADY, push {AWID, AWLEN, AWADDR}.
  - An entry is visible at the head the cycle after the push, so AW-to-first-W latency is 1 cycle minimum.
- W path, zero latency:
  - go = aw_nonempty & ~b_full.
  - TVALID = WVALID & go; WREADY = TREADY & go; TDATA/TKEEP pass straight through.
  - W beats that arrive before their AW are stalled, not accepted.
- Beat counting (8-bit counter):
  - TLAST = (beat_cnt == head.len).
  - Each W handshake increments the counter; the last-beat handshake clears it to 0.
- Mismatch detection:
  - Any beat where WLAST != TLAST sets a sticky mismatch flag for the current burst.
  - The burst still ends on the AWLEN count regardless of WLAST.
- Last-beat handshake:
  - Pop the AW queue.
  - Push {head.id, mismatch ? SLVERR : OKAY} into the B queue.
  - Clear the mismatch flag.
  - If the burst was a mismatch, ERR_COUNT increments and saturates at 0xFFFF.
- B channel:
  - BVALID = b_nonempty, registered from queue state; first BVALID appears 1 cycle after the last W handshake.
  - BID/BRESP come from the B queue head; they hold stable while BVALID & ~BREADY.
  - Responses are in AW order.
- Full and empty boundaries:
  - When the B queue is full, W stalls even if a B pop happens the same cycle (conservative).
  - When the AW queue is full, AWREADY is 0.
  - Simultaneous push and pop on either queue in the same cycle are both honoured.
  - Queue pointers wrap modulo QDEPTH, with a count register for full/empty.
- AWLEN=0 is a single-beat burst: TLAST on the first beat.
- Reset mid-burst: partial burst and pending B responses are discarded; no BVALID after reset.
- AWBURST, AWSIZE and WSTRB contents are not checked.

Optional Feature:
- Macro: AXIS_TUSER_ADDR_EN.
- Defined:
  - Adds port AXIS_OUT_TUSER, out, width AW.
  - Value = head.addr + beat_cnt*(DW/8), INCR semantics, wrapping modulo 2^AW.
  - Valid whenever TVALID is 1.
- Not defined: port absent; the address is not stored, so the AW queue entry is {id, len} only.

Test Plan:
- Single burst: AWID=3, AWLEN=3, four beats with WLAST on beat 4, TREADY=1 -> four stream beats, TLAST on beat 4 only; one B with BID=3, BRESP=0; ERR_COUNT=0.
- Early W: send W beats 5 cycles before AWVALID -> WREADY=0 and TVALID=0 until the cycle after the AW handshake; then data streams in order.
- Mismatch: AWLEN=1, master asserts WLAST on beat 1 and 0 on beat 2 -> TLAST on beat 2; BRESP=2; ERR_COUNT=1.
- Backpressure: QDEPTH=4, issue 6 AWLEN=0 bursts with IDs 0-5 and hold BREADY=0 -> AWREADY drops after 4 queued entries; W stalls once the B queue is full. Releasing BREADY yields BIDs 0-5 in order.
- Reset mid-burst: AWLEN=7, assert resetn=0 after beat 3 -> BVALID=0 and the counter is cleared. A new AWLEN=0 burst then completes with exactly one B.
- AXIS_TUSER_ADDR_EN with DW=512: AWADDR=0x1000, AWLEN=2 -> TUSER = 0x1000, 0x1040, 0x1080.
